// File: rtl/i2c_slave_reg_ctrl.sv
// Register bank and byte sequencer behind an I2C slave: turns the slave's receive/transmit
// handshakes into pointer-addressed register reads and writes, with a parallel host write port.
module i2c_slave_reg_ctrl #(
  parameter int         REG_NUM  = 16,
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_en,
  output logic                         slv_en,
  output logic [6:0]                   slv_addr,
  output logic                         slv_rd_clr,
  output logic                         slv_wr_rdy,
  output logic [7:0]                   slv_wr_byte,
  input  logic                         slv_rd_full,
  input  logic                         slv_wr_empty,
  input  logic [7:0]                   slv_rd_byte,
  input  logic                         slv_match,
  input  logic                         slv_dir,
  input  logic                         slv_stop,
  input  logic                         slv_bus_err,
  input  logic                         host_we,
  input  logic [$clog2(REG_NUM)-1:0]   host_waddr,
  input  logic [7:0]                   host_wdata,
  output logic                         host_collide,
  output logic [REG_NUM*8-1:0]         regs_o,
  output logic                         i2c_wr_stb,
  output logic [$clog2(REG_NUM)-1:0]   i2c_wr_idx,
  output logic [$clog2(REG_NUM)-1:0]   ptr_o
);

  localparam int ADDR_W = $clog2(REG_NUM);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_NUM - 1);

  typedef enum logic [1:0] {S_OFF, S_LISTEN, S_RX_CLR, S_TX_LOAD} state_t;

  state_t            state;
  logic [7:0]        regs [REG_NUM];
  logic [ADDR_W-1:0] ptr;
  logic              first;
  logic              pend;

  logic rx_go, tx_go, rx_wr, pend_clr, pend_drop;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] ptr_dec(input logic [ADDR_W-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  always_comb begin
    rx_go     = ctrl_en && (state == S_LISTEN) && slv_rd_full && !slv_dir;
    tx_go     = ctrl_en && (state == S_LISTEN) && slv_dir && slv_wr_empty && !pend;
    rx_wr     = rx_go && !first;
    // In TX_LOAD the slave has not yet seen wr_rdy, so wr_empty still refers to the old byte
    pend_clr  = pend && ctrl_en && slv_dir && slv_wr_empty && (state != S_TX_LOAD);
    // A prefetched byte the master never clocked out is given back to the pointer
    pend_drop = pend && (!slv_dir || !ctrl_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_OFF;
      slv_en       <= 1'b0;
      slv_rd_clr   <= 1'b0;
      slv_wr_rdy   <= 1'b0;
      slv_wr_byte  <= '0;
      host_collide <= 1'b0;
      i2c_wr_stb   <= 1'b0;
      i2c_wr_idx   <= '0;
      ptr          <= '0;
      first        <= 1'b1;
      pend         <= 1'b0;
    end else begin
      slv_rd_clr   <= 1'b0;
      slv_wr_rdy   <= 1'b0;
      i2c_wr_stb   <= 1'b0;
      host_collide <= host_we && rx_wr;

      if (!ctrl_en) begin
        state  <= S_OFF;
        slv_en <= 1'b0;
      end else begin
        case (state)
          S_OFF: begin
            state  <= S_LISTEN;
            slv_en <= 1'b1;
          end
          S_LISTEN: begin
            if (rx_go) begin
              state      <= S_RX_CLR;
              slv_rd_clr <= 1'b1;
            end else if (tx_go) begin
              state      <= S_TX_LOAD;
              slv_wr_rdy <= 1'b1;
            end
          end
          default: state <= S_LISTEN;
        endcase
      end

      if (rx_go) begin
        if (first) begin
          ptr   <= ({1'b0, slv_rd_byte} < 9'(REG_NUM)) ? slv_rd_byte[ADDR_W-1:0] : '0;
          first <= 1'b0;
        end else begin
          i2c_wr_stb <= 1'b1;
          i2c_wr_idx <= ptr;
          ptr        <= ptr_inc(ptr);
        end
      end

      if (tx_go) begin
        slv_wr_byte <= regs[ptr];
        ptr         <= ptr_inc(ptr);
      end

      if (pend_drop) begin
        ptr  <= ptr_dec(ptr);
        pend <= 1'b0;
      end else if (tx_go) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end

      if (slv_match || slv_stop || slv_bus_err) first <= 1'b1;
    end
  end

  // I2C writes win over host writes landing on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= RST_VAL;
    end else if (rx_wr) begin
      regs[ptr] <= slv_rd_byte;
    end else if (host_we) begin
      regs[host_waddr] <= host_wdata;
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = regs[g];
  end

  assign slv_addr = DEV_ADDR;
  assign ptr_o    = ptr;

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Bench for i2c_slave_reg_ctrl: emulates the slave's byte handshakes and compares against a
// transaction-level register/pointer model plus a table of hand-derived transfers.
module tb_i2c_slave_reg_ctrl;
  localparam int REG_NUM = 16;
  localparam int AW      = 4;

  logic           clk = 1'b0;
  logic           rst_n, ctrl_en;
  logic           slv_en, slv_rd_clr, slv_wr_rdy;
  logic [6:0]     slv_addr;
  logic [7:0]     slv_wr_byte, slv_rd_byte;
  logic           slv_rd_full, slv_wr_empty, slv_match, slv_dir, slv_stop, slv_bus_err;
  logic           host_we, host_collide, i2c_wr_stb;
  logic [AW-1:0]  host_waddr, i2c_wr_idx, ptr_o;
  logic [7:0]     host_wdata;
  logic [REG_NUM*8-1:0] regs_o;

  always #5 clk = ~clk;

  i2c_slave_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en),
    .slv_en(slv_en), .slv_addr(slv_addr), .slv_rd_clr(slv_rd_clr), .slv_wr_rdy(slv_wr_rdy),
    .slv_wr_byte(slv_wr_byte), .slv_rd_full(slv_rd_full), .slv_wr_empty(slv_wr_empty),
    .slv_rd_byte(slv_rd_byte), .slv_match(slv_match), .slv_dir(slv_dir), .slv_stop(slv_stop),
    .slv_bus_err(slv_bus_err), .host_we(host_we), .host_waddr(host_waddr),
    .host_wdata(host_wdata), .host_collide(host_collide), .regs_o(regs_o),
    .i2c_wr_stb(i2c_wr_stb), .i2c_wr_idx(i2c_wr_idx), .ptr_o(ptr_o)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_regs [REG_NUM];
  int         ref_ptr;
  int         stb_q [$];

  always @(negedge clk) if (i2c_wr_stb) stb_q.push_back(int'(i2c_wr_idx));

  typedef struct {
    bit          rd;
    logic [7:0]  start;
    int          n;
    logic [31:0] d;
    int          base;
    int          exp_ptr;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input bit tx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx ? slv_wr_rdy : slv_rd_clr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bit ok;
    slv_rd_byte = b;
    slv_rd_full = 1'b1;
    wait_pulse(1'b0, ok);
    chk("rd_clr_seen", 32'(ok), 32'd1);
    slv_rd_full = 1'b0;
    @(negedge clk);
  endtask

  task automatic master_write(input logic [7:0] start, input int n, input logic [31:0] d);
    slv_dir   = 1'b0;
    slv_match = 1'b1;
    @(negedge clk);
    slv_match = 1'b0;
    rx_byte(start);
    ref_ptr = (int'(start) < REG_NUM) ? int'(start) : 0;
    for (int k = 0; k < n; k++) begin
      rx_byte(d[8*k +: 8]);
      ref_regs[ref_ptr] = d[8*k +: 8];
      ref_ptr = (ref_ptr + 1) % REG_NUM;
    end
    slv_stop = 1'b1;
    @(negedge clk);
    slv_stop = 1'b0;
  endtask

  task automatic master_read(input int n, output logic [31:0] got);
    bit ok;
    got = '0;
    slv_match = 1'b1;
    @(negedge clk);
    slv_match    = 1'b0;
    slv_dir      = 1'b1;
    slv_wr_empty = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_pulse(1'b1, ok);
      chk("wr_rdy_seen", 32'(ok), 32'd1);
      got[8*k +: 8] = slv_wr_byte;
      slv_wr_empty = 1'b0;
      repeat (2) @(negedge clk);
      slv_wr_empty = 1'b1;
    end
    // the byte taken last frees the buffer, so one extra byte gets prefetched before stop
    wait_pulse(1'b1, ok);
    chk("prefetch_seen", 32'(ok), 32'd1);
    slv_wr_empty = 1'b0;
    @(negedge clk);
    slv_dir  = 1'b0;
    slv_stop = 1'b1;
    @(negedge clk);
    slv_stop = 1'b0;
    @(negedge clk);
    for (int k = 0; k < n; k++)
      chk($sformatf("rd_byte%0d", k), 32'(got[8*k +: 8]), 32'(ref_regs[(ref_ptr + k) % REG_NUM]));
    ref_ptr = (ref_ptr + n) % REG_NUM;
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_ptr", tag), 32'(ptr_o), 32'(ref_ptr));
    for (int i = 0; i < REG_NUM; i++)
      chk($sformatf("%s_reg%0d", tag, i), 32'(regs_o[8*i +: 8]), 32'(ref_regs[i]));
  endtask

  logic [31:0] got;
  logic [7:0]  saved;
  int          p;
  bit          ok;

  initial begin
    vecs[0] = '{1'b0, 8'h03, 2, 32'h0000BBAA, 3,  5, 32'h0000BBAA};
    vecs[1] = '{1'b0, 8'h0F, 2, 32'h00002211, 15, 1, 32'h00002211};
    vecs[2] = '{1'b0, 8'h05, 3, 32'h00030201, 5,  8, 32'h00030201};
    vecs[3] = '{1'b0, 8'h05, 0, 32'h0,        5,  5, 32'h0};
    vecs[4] = '{1'b1, 8'h00, 3, 32'h0,        0,  8, 32'h00030201};
    vecs[5] = '{1'b0, 8'h0F, 0, 32'h0,        15, 15, 32'h0};
    vecs[6] = '{1'b1, 8'h00, 2, 32'h0,        0,  1, 32'h00002211};
    vecs[7] = '{1'b0, 8'h20, 1, 32'h00000077, 0,  1, 32'h00000077};
    vecs[8] = '{1'b0, 8'h10, 0, 32'h0,        0,  0, 32'h0};

    rst_n = 1'b0; ctrl_en = 1'b0;
    slv_rd_full = 1'b0; slv_wr_empty = 1'b0; slv_rd_byte = '0; slv_match = 1'b0;
    slv_dir = 1'b0; slv_stop = 1'b0; slv_bus_err = 1'b0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0;
    for (int i = 0; i < REG_NUM; i++) ref_regs[i] = 8'h00;
    ref_ptr = 0;
    repeat (3) @(negedge clk);

    chk("rst_slv_en", 32'(slv_en), 32'd0);
    chk("rst_rd_clr", 32'(slv_rd_clr), 32'd0);
    chk("rst_wr_rdy", 32'(slv_wr_rdy), 32'd0);
    chk("rst_wr_byte", 32'(slv_wr_byte), 32'd0);
    chk("rst_collide", 32'(host_collide), 32'd0);
    chk("rst_stb", 32'(i2c_wr_stb), 32'd0);
    chk("rst_slv_addr", 32'(slv_addr), 32'h50);
    check_all("rst");

    rst_n = 1'b1;
    @(negedge clk);
    chk("off_slv_en", 32'(slv_en), 32'd0);
    ctrl_en = 1'b1;
    @(negedge clk);
    chk("on_slv_en", 32'(slv_en), 32'd1);

    for (int i = 0; i < 9; i++) begin
      stb_q.delete();
      if (vecs[i].rd) begin
        master_read(vecs[i].n, got);
        for (int k = 0; k < vecs[i].n; k++)
          chk($sformatf("v%0d_rd%0d", i, k), 32'(got[8*k +: 8]), 32'(vecs[i].e[8*k +: 8]));
      end else begin
        master_write(vecs[i].start, vecs[i].n, vecs[i].d);
        for (int k = 0; k < vecs[i].n; k++)
          chk($sformatf("v%0d_reg", i), 32'(regs_o[8*((vecs[i].base + k) % REG_NUM) +: 8]),
              32'(vecs[i].e[8*k +: 8]));
        chk($sformatf("v%0d_stb_cnt", i), 32'(stb_q.size()), 32'(vecs[i].n));
        for (int k = 0; k < vecs[i].n && k < stb_q.size(); k++)
          chk($sformatf("v%0d_stb_idx%0d", i, k), 32'(stb_q[k]), 32'((vecs[i].base + k) % REG_NUM));
      end
      chk($sformatf("v%0d_ptr", i), 32'(ptr_o), 32'(vecs[i].exp_ptr));
    end
    check_all("table");

    // plain host write while idle
    host_we = 1'b1; host_waddr = 4'd2; host_wdata = 8'hC3;
    @(negedge clk);
    host_we = 1'b0;
    ref_regs[2] = 8'hC3;
    chk("host_wr_reg2", 32'(regs_o[8*2 +: 8]), 32'hC3);
    chk("host_wr_nocollide", 32'(host_collide), 32'd0);

    // host write colliding with an I2C data write to another index
    slv_dir = 1'b0; slv_match = 1'b1;
    @(negedge clk);
    slv_match = 1'b0;
    rx_byte(8'h09);
    slv_rd_byte = 8'h5A; slv_rd_full = 1'b1;
    host_we = 1'b1; host_waddr = 4'd2; host_wdata = 8'h3C;
    @(negedge clk);
    host_we = 1'b0;
    chk("coll_collide", 32'(host_collide), 32'd1);
    chk("coll_stb", 32'(i2c_wr_stb), 32'd1);
    chk("coll_idx", 32'(i2c_wr_idx), 32'd9);
    slv_rd_full = 1'b0;
    @(negedge clk);
    chk("coll_collide_drop", 32'(host_collide), 32'd0);
    slv_stop = 1'b1;
    @(negedge clk);
    slv_stop = 1'b0;
    ref_regs[9] = 8'h5A;
    ref_ptr = 10;
    chk("coll_reg9", 32'(regs_o[8*9 +: 8]), 32'h5A);
    chk("coll_reg2", 32'(regs_o[8*2 +: 8]), 32'hC3);
    check_all("coll");

    // disable while a prefetched byte is pending
    p = ref_ptr;
    slv_match = 1'b1;
    @(negedge clk);
    slv_match = 1'b0; slv_dir = 1'b1; slv_wr_empty = 1'b1;
    wait_pulse(1'b1, ok);
    chk("dis_wr_rdy_seen", 32'(ok), 32'd1);
    chk("dis_byte", 32'(slv_wr_byte), 32'(ref_regs[p]));
    chk("dis_ptr_adv", 32'(ptr_o), 32'((p + 1) % REG_NUM));
    slv_wr_empty = 1'b0;
    @(negedge clk);
    ctrl_en = 1'b0;
    @(negedge clk);
    chk("dis_slv_en", 32'(slv_en), 32'd0);
    chk("dis_ptr_back", 32'(ptr_o), 32'(p));
    slv_dir = 1'b0;
    @(negedge clk);
    chk("dis_ptr_hold", 32'(ptr_o), 32'(p));
    chk("dis_wr_rdy_low", 32'(slv_wr_rdy), 32'd0);
    ctrl_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reen_slv_en", 32'(slv_en), 32'd1);
    master_read(1, got);
    check_all("reen");

    // randomized transfers against the transaction model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: master_write(8'($urandom_range(0, 23)), int'($urandom_range(0, 4)), $urandom);
        1: master_read(int'($urandom_range(1, 3)), got);
        default: begin
          host_waddr = AW'($urandom_range(0, REG_NUM - 1));
          host_wdata = 8'($urandom);
          host_we = 1'b1;
          @(negedge clk);
          host_we = 1'b0;
          ref_regs[int'(host_waddr)] = host_wdata;
        end
      endcase
      check_all($sformatf("rnd%0d", t));
    end

    // reset for one edge in the middle of a write transfer
    slv_dir = 1'b0; slv_match = 1'b1;
    @(negedge clk);
    slv_match = 1'b0;
    rx_byte(8'h04);
    slv_rd_byte = 8'h99; slv_rd_full = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; slv_rd_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < REG_NUM; i++) ref_regs[i] = 8'h00;
    ref_ptr = 0;
    chk("mrst_slv_en", 32'(slv_en), 32'd0);
    chk("mrst_rd_clr", 32'(slv_rd_clr), 32'd0);
    chk("mrst_stb", 32'(i2c_wr_stb), 32'd0);
    chk("mrst_wr_rdy", 32'(slv_wr_rdy), 32'd0);
    check_all("mrst");
    @(negedge clk);
    chk("mrst_relisten", 32'(slv_en), 32'd1);
    master_write(8'h02, 1, 32'h44);
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
